cordic_pair_scheduler: RTL and testbench

Sequencing controller that shares one iterative CORDIC core between the two operands produced by the stage 1 front end. It accepts an operand pair on `start` and issues each operand to the core in turn with a start/done handshake. It captures both results and signals completion with a single `done` pulse. A per-request watchdog guarantees that a hung core cannot stall the pipeline.

---
 rtl/cordic_pair_scheduler.sv | 148 ++++++++++++++
 tb/tb_cordic_pair_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pair_scheduler.sv
// Shares one iterative CORDIC core between two operands: issues A, then B, each guarded by a
// watchdog, and reports both results with a single done pulse.
module cordic_pair_scheduler #(
    parameter int CORDIC_DATA_WIDTH = 22,
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int TIMEOUT_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         start,
    input  logic [CORDIC_DATA_WIDTH-1:0] x_one,
    input  logic [CORDIC_DATA_WIDTH-1:0] x_two,
    output logic                         busy,
    output logic                         cordic_start,
    output logic [CORDIC_DATA_WIDTH-1:0] cordic_x,
    input  logic                         cordic_done,
    input  logic [CORDIC_DATA_WIDTH-1:0] cordic_result,
    output logic                         done,
    output logic [CORDIC_DATA_WIDTH-1:0] result_one,
    output logic [CORDIC_DATA_WIDTH-1:0] result_two,
    output logic                         timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_A,
        S_WAIT_A,
        S_ISSUE_B,
        S_WAIT_B,
        S_DONE
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                         state_q, state_d;
    logic [CORDIC_DATA_WIDTH-1:0]   x_two_q, x_two_d;
    logic [TIMEOUT_WIDTH-1:0]       wdog_q, wdog_d;
    logic                           busy_q, busy_d;
    logic                           cordic_start_q, cordic_start_d;
    logic [CORDIC_DATA_WIDTH-1:0]   cordic_x_q, cordic_x_d;
    logic                           done_q, done_d;
    logic [CORDIC_DATA_WIDTH-1:0]   result_one_q, result_one_d;
    logic [CORDIC_DATA_WIDTH-1:0]   result_two_q, result_two_d;
    logic                           timeout_q, timeout_d;
    logic [CORDIC_DATA_WIDTH-1:0]   captured;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
        state_d        = state_q;
        x_two_d        = x_two_q;
        wdog_d         = wdog_q;
        busy_d         = busy_q;
        cordic_start_d = cordic_start_q;
        cordic_x_d     = cordic_x_q;
        done_d         = done_q;
        result_one_d   = result_one_q;
        result_two_d   = result_two_q;
        timeout_d      = timeout_q;
        captured       = cordic_done ? cordic_result : '0;

        // With clk_en low everything holds, including a pending start or done pulse.
        if (clk_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cordic_x_d = x_one;
                        x_two_d    = x_two;
                        timeout_d  = 1'b0;
                        state_d    = S_ISSUE_A;
                    end
                end
                S_ISSUE_A: begin
                    wdog_d  = '0;
                    state_d = S_WAIT_A;
                end
                S_ISSUE_B: begin
                    wdog_d  = '0;
                    state_d = S_WAIT_B;
                end
                S_WAIT_A, S_WAIT_B: begin
                    // A done on the final watchdog cycle wins over the expiry.
                    if (cordic_done || wdog_q == WDOG_LAST) begin
                        if (!cordic_done) begin
                            timeout_d = 1'b1;
                        end
                        if (state_q == S_WAIT_A) begin
                            result_one_d = captured;
                            cordic_x_d   = x_two_q;
                            state_d      = S_ISSUE_B;
                        end else begin
                            result_two_d = captured;
                            state_d      = S_DONE;
                        end
                    end else begin
                        wdog_d = wdog_q + TIMEOUT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            busy_d         = (state_d != S_IDLE);
            cordic_start_d = (state_d == S_ISSUE_A) || (state_d == S_ISSUE_B);
            done_d         = (state_d == S_DONE);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            x_two_q        <= '0;
            wdog_q         <= '0;
            busy_q         <= 1'b0;
            cordic_start_q <= 1'b0;
            cordic_x_q     <= '0;
            done_q         <= 1'b0;
            result_one_q   <= '0;
            result_two_q   <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_two_q        <= x_two_d;
            wdog_q         <= wdog_d;
            busy_q         <= busy_d;
            cordic_start_q <= cordic_start_d;
            cordic_x_q     <= cordic_x_d;
            done_q         <= done_d;
            result_one_q   <= result_one_d;
            result_two_q   <= result_two_d;
            timeout_q      <= timeout_d;
        end
    end

    assign busy         = busy_q;
    assign cordic_start = cordic_start_q;
    assign cordic_x     = cordic_x_q;
    assign done         = done_q;
    assign result_one   = result_one_q;
    assign result_two   = result_two_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_cordic_pair_scheduler.sv
// Bench for cordic_pair_scheduler: two instances (watchdog 255 and 4) share stimulus, each with its own
// core model; a transaction-timeline model predicts every output each cycle.
module tb_cordic_pair_scheduler;

    localparam int W = 22;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x_one = '0;
    logic [W-1:0] x_two = '0;

    logic [1:0]   busy_o, cs_o, done_o, to_o, cdone;
    logic [W-1:0] cx_o [2];
    logic [W-1:0] r1_o [2];
    logic [W-1:0] r2_o [2];
    logic [W-1:0] cres [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int lat  [2] = '{16, 16};
    bit resp [2] = '{1'b1, 1'b1};
    bit stray[2] = '{1'b0, 1'b0};
    int tmo  [2] = '{255, 4};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cordic_pair_scheduler dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .x_one(x_one), .x_two(x_two),
        .busy(busy_o[0]), .cordic_start(cs_o[0]), .cordic_x(cx_o[0]), .cordic_done(cdone[0]),
        .cordic_result(cres[0]), .done(done_o[0]), .result_one(r1_o[0]), .result_two(r2_o[0]),
        .timeout(to_o[0])
    );

    cordic_pair_scheduler #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .x_one(x_one), .x_two(x_two),
        .busy(busy_o[1]), .cordic_start(cs_o[1]), .cordic_x(cx_o[1]), .cordic_done(cdone[1]),
        .cordic_result(cres[1]), .done(done_o[1]), .result_one(r1_o[1]), .result_two(r2_o[1]),
        .timeout(to_o[1])
    );

    // Core models: done L enabled edges after the start cycle, result = operand + 1, frozen by clk_en.
    int           rem[2];
    logic [W-1:0] op [2];
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                rem[i] <= 0;
                op[i]  <= '0;
            end else if (clk_en) begin
                if (cs_o[i]) begin
                    rem[i] <= lat[i];
                    op[i]  <= cx_o[i];
                end else if (rem[i] != 0) begin
                    rem[i] <= rem[i] - 1;
                end
            end
        end
    end
    assign cdone[0] = (resp[0] && rem[0] == 1) || stray[0];
    assign cdone[1] = (resp[1] && rem[1] == 1) || stray[1];
    assign cres[0]  = stray[0] ? 22'h3FFFFF : op[0] + 22'd1;
    assign cres[1]  = stray[1] ? 22'h3FFFFF : op[1] + 22'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-timeline model: p counts enabled edges since acceptance; r is the per-request
    // wait length (core latency, or the full watchdog when the core is late or silent).
    bit           act [2];
    int           p   [2];
    int           r   [2];
    bit           ta  [2];
    logic [W-1:0] mx1 [2];
    logic [W-1:0] mx2 [2];
    bit           e_busy[2], e_cs[2], e_done[2], e_to[2];
    logic [W-1:0] e_cx[2], e_r1[2], e_r2[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                act[i] = 0; p[i] = 0;
                e_busy[i] = 0; e_cs[i] = 0; e_done[i] = 0; e_to[i] = 0;
                e_cx[i] = '0; e_r1[i] = '0; e_r2[i] = '0;
            end
            check($sformatf("busy%0d", i),         busy_o[i], e_busy[i]);
            check($sformatf("cordic_start%0d", i), cs_o[i],   e_cs[i]);
            check($sformatf("cordic_x%0d", i),     cx_o[i],   e_cx[i]);
            check($sformatf("done%0d", i),         done_o[i], e_done[i]);
            check($sformatf("result_one%0d", i),   r1_o[i],   e_r1[i]);
            check($sformatf("result_two%0d", i),   r2_o[i],   e_r2[i]);
            check($sformatf("timeout%0d", i),      to_o[i],   e_to[i]);
            if (rst && clk_en) begin
                if (!act[i] && start) begin
                    act[i] = 1; p[i] = 0;
                    mx1[i] = x_one; mx2[i] = x_two;
                    ta[i]  = !(resp[i] && lat[i] <= tmo[i]);
                    r[i]   = ta[i] ? tmo[i] : lat[i];
                end
                if (act[i]) begin
                    p[i]++;
                    e_busy[i] = (p[i] <= 3 + 2 * r[i]);
                    e_cs[i]   = (p[i] == 1) || (p[i] == 2 + r[i]);
                    e_done[i] = (p[i] == 3 + 2 * r[i]);
                    if (p[i] == 1) begin
                        e_cx[i] = mx1[i];
                        e_to[i] = 0;
                    end
                    if (p[i] == 2 + r[i]) begin
                        e_cx[i] = mx2[i];
                        e_r1[i] = ta[i] ? '0 : mx1[i] + 22'd1;
                        if (ta[i]) e_to[i] = 1;
                    end
                    if (p[i] == 3 + 2 * r[i]) begin
                        e_r2[i] = ta[i] ? '0 : mx2[i] + 22'd1;
                        if (ta[i]) e_to[i] = 1;
                    end
                    if (p[i] == 4 + 2 * r[i]) act[i] = 0;
                end
            end
        end
    end

    // Rising-edge bookkeeping for done pulses and cordic_start issues.
    int done_cnt[2] = '{0, 0};
    int cs_last [2] = '{0, 0};
    bit done_prev[2], cs_prev[2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done_o[i] && !done_prev[i]) done_cnt[i]++;
            if (cs_o[i] && !cs_prev[i]) cs_last[i] = cyc;
            done_prev[i] = done_o[i];
            cs_prev[i]   = cs_o[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, output int s);
        step();
        start = 1'b1; x_one = a; x_two = b;
        s = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int i, input int s, input int budget, output int off);
        off = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_o[i]) begin
                off = cyc - s;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (busy_o == 2'b00) break;
        end
        check("idle_reached", busy_o, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int s, off, dc;
        #1 rst = 1'b0;
        repeat (3) step();
        check("reset_busy", busy_o, 2'b00);
        check("reset_done", done_o, 2'b00);
        check("reset_result_one", r1_o[0], 0);
        rst = 1'b1; clk_en = 1'b1;
        repeat (2) step();

        // Nominal pair, L = 16.
        lat = '{16, 16}; resp = '{1'b1, 1'b1};
        do_start(22'h00100, 22'h00200, s);
        @(negedge clk);
        check("t1_cs_a_cycle", cs_o[0], 1'b1);
        wait_done(0, s, 100, off);
        check("t1_done_cycle", off, 35);
        check("t1_cs_b_cycle", cs_last[0] - s, 18);
        check("t1_result_one", r1_o[0], 22'h00101);
        check("t1_result_two", r2_o[0], 22'h00201);
        check("t1_timeout", to_o[0], 1'b0);
        wait_idle();

        // Silent core on the 4-cycle watchdog instance.
        lat = '{2, 2}; resp = '{1'b1, 1'b0};
        do_start(22'h00AAA, 22'h00BBB, s);
        wait_done(1, s, 100, off);
        check("t2_done_cycle", off, 11);
        check("t2_result_one", r1_o[1], 0);
        check("t2_result_two", r2_o[1], 0);
        check("t2_timeout", to_o[1], 1'b1);
        wait_idle();

        // start held while busy, stray done in the ISSUE_B cycle of instance 0.
        lat = '{3, 3}; resp = '{1'b1, 1'b1};
        dc = done_cnt[0];
        step();
        start = 1'b1; x_one = 22'h01000; x_two = 22'h02000;
        s = cyc;
        for (int k = 1; k <= 12; k++) begin
            step();
            start    = (k <= 9);
            x_one    = 22'h00F00 + 22'(k);
            x_two    = 22'h00E00 + 22'(k);
            stray[0] = (k == 5);
            if (k == 1) begin
                @(negedge clk);
                check("t3_timeout_cleared", to_o[1], 1'b0);
            end
        end
        start = 1'b0; stray[0] = 1'b0;
        wait_idle();
        check("t3_single_done", done_cnt[0] - dc, 1);
        check("t3_result_one", r1_o[0], 22'h01001);
        check("t3_result_two", r2_o[0], 22'h02001);

        // clk_en low for 5 cycles while the core holds done in WAIT_A.
        lat = '{4, 4};
        do_start(22'h00300, 22'h00400, s);
        repeat (4) step();
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_frozen_core_done", cdone[0], 1'b1);
            check("t4_frozen_busy", busy_o[0], 1'b1);
            step();
        end
        clk_en = 1'b1;
        wait_done(0, s, 100, off);
        check("t4_done_cycle", off, 16);
        check("t4_result_one", r1_o[0], 22'h00301);
        check("t4_result_two", r2_o[0], 22'h00401);
        wait_idle();

        // Asynchronous reset in WAIT_B, then a fresh transaction.
        lat = '{5, 5};
        do_start(22'h00500, 22'h00600, s);
        repeat (8) step();
        check("t5_busy_before_reset", busy_o[0], 1'b1);
        check("t5_result_one_before_reset", r1_o[0], 22'h00501);
        dc = done_cnt[0];
        rst = 1'b0;
        #1;
        check("t5_async_busy", busy_o, 2'b00);
        check("t5_async_result_one", r1_o[0], 0);
        check("t5_async_cordic_x", cx_o[0], 0);
        repeat (2) step();
        rst = 1'b1;
        repeat (15) step();
        check("t5_no_done", done_cnt[0] - dc, 0);
        lat = '{2, 2};
        do_start(22'h00700, 22'h00800, s);
        wait_done(0, s, 100, off);
        check("t5_done_cycle", off, 7);
        check("t5_result_one", r1_o[0], 22'h00701);
        check("t5_result_two", r2_o[0], 22'h00801);
        wait_idle();

        // Done on the final watchdog cycle (T = 4, L = 4).
        lat = '{4, 4};
        do_start(22'h00900, 22'h00A00, s);
        wait_done(1, s, 100, off);
        check("t6_done_cycle", off, 11);
        check("t6_result_one", r1_o[1], 22'h00901);
        check("t6_result_two", r2_o[1], 22'h00A01);
        check("t6_timeout", to_o[1], 1'b0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
